// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
// Shared definitions for the ALU issue stage: opcode encoding of the
// 4-bit combinational ALU, the last legal opcode, the opcode driven while
// no operation is in flight, the FSM state type and the packed request
// record held in the request FIFO.
package alu_issue_stage_pkg;

  typedef enum logic [3:0] {
    OPC_ADD  = 4'h0,
    OPC_SUB  = 4'h1,
    OPC_MUL  = 4'h2,
    OPC_DIV  = 4'h3,
    OPC_MOD  = 4'h4,
    OPC_AND  = 4'h5,
    OPC_OR   = 4'h6,
    OPC_XOR  = 4'h7,
    OPC_NAND = 4'h8,
    OPC_NOR  = 4'h9,
    OPC_XNOR = 4'hA
  } opc_e;

  localparam logic [3:0] OPC_LAST     = 4'hA;
  // Undefined opcode parked on the ALU bus between issues so every issue
  // produces a visible opcode transition.
  localparam logic [3:0] IDLE_OPC_DEF = 4'hF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] opc;
    logic [3:0] a;
    logic [3:0] b;
  } req_t;

endpackage

// File: rtl/alu_issue_stage_req_fifo.sv
// alu_issue_stage_req_fifo
// Request buffer for the ALU issue stage: DEPTH entries of WIDTH bits,
// first-word-fall-through read (rdata always shows the oldest entry).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   push, wdata  write one entry (ignored when full)
//   pop          drop the oldest entry (ignored when empty)
//   rdata        oldest entry, valid while !empty
//   full, empty  occupancy flags
module alu_issue_stage_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is governed by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Sequential front end for the 4-bit combinational ALU. Requests
// {opcode,a,b} are buffered in a FIFO, issued one at a time on the
// registered alu_* bus, and the ALU answer is captured one cycle later
// and held on a valid/ready result port.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready = FIFO not full)
//   req_opc, req_a, req_b          request fields
//   alu_opc, alu_a, alu_b          registered operands to the ALU
//   alu_res, alu_flag              combinational ALU answer
//   res_valid/res_ready            result handshake
//   res_data, res_flag, res_err    captured result, carry/borrow, error
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [3:0] IDLE_OPC = IDLE_OPC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_opc,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  output logic [3:0] alu_opc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [7:0] alu_res,
  input  logic       alu_flag,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_flag,
  output logic       res_err
);

  state_t state;
  req_t   head;
  req_t   wreq;
  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;

  // Result classification: returns {err, flag, data}. Illegal opcodes and
  // divide-by-zero override whatever the ALU drove; only add/sub expose
  // the ALU flag.
  function automatic logic [9:0] capture_result(input logic [3:0] opc,
                                                input logic [3:0] b,
                                                input logic [7:0] res,
                                                input logic       flag);
    logic [9:0] r;
    if (opc > OPC_LAST)
      r = {1'b1, 1'b0, 8'h00};
    else if (opc == OPC_DIV && b == 4'd0)
      r = {1'b1, 1'b0, 8'hFF};
    else if (opc == OPC_ADD || opc == OPC_SUB)
      r = {1'b0, flag, res};
    else
      r = {1'b0, 1'b0, res};
    return r;
  endfunction

  assign wreq      = '{opc: req_opc, a: req_a, b: req_b};
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  // An issue needs an empty result slot; the slot freeing in this cycle is
  // only seen next cycle, which sets the 1-per-3-cycles cadence.
  assign pop       = (state == ST_IDLE) && !fifo_empty && !res_valid;

  alu_issue_stage_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wreq),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      alu_opc   <= IDLE_OPC;
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      res_valid <= 1'b0;
      res_data  <= 8'd0;
      res_flag  <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        // Issue boundary: oldest request moves onto the ALU bus.
        ST_IDLE: begin
          if (res_valid && res_ready) res_valid <= 1'b0;
          if (pop) begin
            state   <= ST_ISSUE;
            alu_opc <= head.opc;
            alu_a   <= head.a;
            alu_b   <= head.b;
          end
        end
        // Capture boundary: ALU has settled for one cycle; latch its answer.
        ST_ISSUE: begin
          state     <= ST_IDLE;
          alu_opc   <= IDLE_OPC;
          {res_err, res_flag, res_data} <= capture_result(alu_opc, alu_b, alu_res, alu_flag);
          res_valid <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_opc, req_a, req_b;
  logic [3:0] alu_opc, alu_a, alu_b;
  logic [7:0] alu_res;
  logic       alu_flag;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_flag;
  logic       res_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic rdy_fixed = 1'b1;
  logic rdy_rand  = 1'b0;
  logic [9:0] exp_q[$];

  alu_issue_stage #(.DEPTH(4), .IDLE_OPC(4'hF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opc   (req_opc),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_opc   (alu_opc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_res   (alu_res),
    .alu_flag  (alu_flag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flag  (res_flag),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 4-bit ALU: {flag, data}. Non add/sub flags and illegal-code
  // results are deliberately non-zero so masking in the DUT is observable.
  function automatic logic [8:0] alu_fn(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] d;
    logic       f;
    f = ^{a, b};
    case (o)
      4'h0: begin d = 8'(a) + 8'(b); f = d[4]; end
      4'h1: begin d = {4'h0, 4'(a - b)}; f = (a < b); end
      4'h2: d = 8'(a) * 8'(b);
      4'h3: d = (b != 0) ? 8'(a / b) : 8'h00;
      4'h4: d = (b != 0) ? 8'(a % b) : 8'h00;
      4'h5: d = {4'h0, a & b};
      4'h6: d = {4'h0, a | b};
      4'h7: d = {4'h0, a ^ b};
      4'h8: d = {4'h0, ~(a & b)};
      4'h9: d = {4'h0, ~(a | b)};
      4'hA: d = {4'h0, ~(a ^ b)};
      default: begin d = 8'hA5; f = 1'b1; end
    endcase
    return {f, d};
  endfunction

  // Expected {err, flag, data} for a request.
  function automatic logic [9:0] exp_fn(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b);
    logic [8:0] r;
    r = alu_fn(o, a, b);
    if (o > 4'hA)               return {1'b1, 1'b0, 8'h00};
    if (o == 4'h3 && b == 4'h0) return {1'b1, 1'b0, 8'hFF};
    if (o <= 4'h1)              return {1'b0, r[8], r[7:0]};
    return {1'b0, 1'b0, r[7:0]};
  endfunction

  always_comb {alu_flag, alu_res} = alu_fn(alu_opc, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Result consumer handshake driver (single writer of res_ready).
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      res_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Scoreboard: pushes recorded in order, every presented result compared,
  // held results must stay stable.
  logic       hold = 1'b0;
  logic [9:0] held = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 32'(res_valid), 32'd1);
        chk("hold_data", 32'({res_err, res_flag, res_data}), 32'(held));
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          timeout_fail("spurious_result");
        end else begin
          chk("result", 32'({res_err, res_flag, res_data}), 32'(exp_q[0]));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      hold = res_valid && !res_ready;
      held = {res_err, res_flag, res_data};
      if (req_valid && req_ready) exp_q.push_back(exp_fn(req_opc, req_a, req_b));
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_opc = o; req_a = a; req_b = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("push_ready");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !res_valid) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail(name);
    @(posedge clk); #1;
  endtask

  task automatic op_check(input string name, input logic [3:0] o, input logic [3:0] a,
                          input logic [3:0] b, input logic [9:0] expv);
    bit ok;
    ok = 1'b0;
    push(o, a, b);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        chk(name, 32'({res_err, res_flag, res_data}), 32'(expv));
        break;
      end
    end
    if (!ok) timeout_fail(name);
    wait_idle({name, "_drain"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[$];
    int t0;
    bit seen;
    logic [3:0] o, a, b;

    rst_n = 1'b0; req_valid = 1'b0; req_opc = 4'h0; req_a = 4'h0; req_b = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_alu_opc", 32'(alu_opc), 32'hF);
    chk("rst_alu_ab", 32'({alu_a, alu_b}), 32'h0);
    chk("rst_res", 32'({res_valid, res_err, res_flag, res_data}), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: push at edge E0, issue at E1, result visible after E2.
    req_valid = 1'b1; req_opc = OPC_ADD; req_a = 4'd9; req_b = 4'd8;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); chk("lat_e0_valid", 32'(res_valid), 32'd0);
    @(negedge clk); chk("lat_e1_valid", 32'(res_valid), 32'd0);
    chk("lat_e1_alu_bus", 32'({alu_opc, alu_a, alu_b}), 32'h098);
    @(negedge clk); chk("lat_e2_valid", 32'(res_valid), 32'd1);
    chk("add_9_8", 32'({res_err, res_flag, res_data}), 32'h111);
    chk("lat_e2_alu_idle", 32'(alu_opc), 32'hF);
    wait_idle("lat_drain");

    op_check("div_7_0",   OPC_DIV, 4'd7,  4'd0,  10'h2FF);
    op_check("opc_c",     4'hC,    4'd3,  4'd4,  10'h200);
    op_check("opc_f",     4'hF,    4'd1,  4'd1,  10'h200);
    op_check("sub_3_5",   OPC_SUB, 4'd3,  4'd5,  10'h10E);
    op_check("and_d_a",   OPC_AND, 4'hD,  4'hA,  10'h008);
    op_check("div_9_2",   OPC_DIV, 4'd9,  4'd2,  10'h004);
    op_check("mul_f_f",   OPC_MUL, 4'hF,  4'hF,  10'h0E1);
    op_check("xnor_a_5",  OPC_XNOR,4'hA,  4'h5,  10'h000);

    // Back-pressure: one in flight/held plus four queued fills the FIFO.
    rdy_fixed = 1'b0;
    @(posedge clk); #2;
    t0 = cyc;
    push(OPC_ADD, 4'd1, 4'd2);
    push(OPC_MUL, 4'd3, 4'd4);
    push(OPC_XOR, 4'hF, 4'h0);
    push(OPC_NOR, 4'h0, 4'h0);
    push(OPC_SUB, 4'd2, 4'd7);
    chk("bp_push_cycles", 32'(cyc - t0), 32'd5);
    @(negedge clk); chk("bp_full_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_opc = OPC_OR; req_a = 4'd1; req_b = 4'd1;
    repeat (6) begin
      @(negedge clk); chk("bp_refused", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    rdy_fixed = 1'b1;
    for (int i = 0; i < 80 && acc.size() < 5; i++) begin
      @(negedge clk);
      if (res_valid && res_ready) acc.push_back(cyc);
    end
    chk("bp_result_count", 32'(acc.size()), 32'd5);
    for (int i = 1; i < acc.size(); i++) chk("bp_interval", 32'(acc[i] - acc[i-1]), 32'd3);
    wait_idle("bp_drain");
    chk("bp_last_data", 32'({res_flag, res_data}), 32'h10B);

    // Reset while an operation is on the ALU bus and another is queued.
    push(OPC_OR, 4'd5, 4'd3);
    push(OPC_XOR, 4'd6, 4'd9);
    chk("mid_issue_bus", 32'({alu_opc, alu_a, alu_b}), 32'h653);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_opc", 32'(alu_opc), 32'hF);
    chk("mid_rst_alu_ab", 32'({alu_a, alu_b}), 32'h0);
    chk("mid_rst_res", 32'({res_valid, res_err, res_flag, res_data}), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);
    chk("mid_rst_ready_after", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Random traffic with random consumer back-pressure.
    rdy_rand = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      o = 4'($urandom_range(0, 15));
      a = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      push(o, a, b);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rdy_rand = 1'b0;
    wait_idle("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
